// File: rtl/mem_access_stage.sv
//-----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of a five-stage pipeline. It takes the EX/MEM bundle, performs at
// most one data-memory access per instruction over a simple req/ack bus, and
// produces the registered MEM/WB bundle for the writeback stage.
//
// Ports
//   clk, rst            : clock (rising edge) and synchronous active-high reset
//   in_valid            : EX/MEM instruction present
//   in_Instruction,
//   in_PC_plus_4,
//   in_Alu_result,
//   in_Store_data       : EX/MEM payload (in_Alu_result doubles as the address)
//   in_MemRead,
//   in_MemWrite, in_Jal,
//   in_MemtoReg,
//   in_RegDst,
//   in_RegWrite         : EX/MEM control bits
//   mem_stall           : combinational stall back to the upstream stages
//   dmem_req, dmem_we,
//   dmem_addr,
//   dmem_wdata          : data-memory request (held stable while accessing)
//   dmem_ack, dmem_rdata: data-memory response
//   Instruction,
//   PC_plus_4,
//   Mem_read_data,
//   Alu_result, Jal,
//   MemtoReg, RegDst,
//   RegWrite, wb_valid  : registered MEM/WB bundle
//   misalign_err        : pulse in the cycle a misaligned memory op is presented
//   bus_err             : sticky, set when an access times out; cleared by rst
//
// TIMEOUT_CYCLES (1..255) is the number of ACCESS cycles granted to dmem_ack.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_Instruction,
    input  logic [31:0] in_PC_plus_4,
    input  logic [31:0] in_Alu_result,
    input  logic [31:0] in_Store_data,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_Jal,
    input  logic        in_MemtoReg,
    input  logic        in_RegDst,
    input  logic        in_RegWrite,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_plus_4,
    output logic [31:0] Mem_read_data,
    output logic [31:0] Alu_result,
    output logic        Jal,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        wb_valid,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Counter value seen during the last ACCESS cycle that may still be acked.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  acc_cnt_r;

    logic        mem_op_s;
    logic        aligned_s;
    logic        start_s;
    logic        complete_s;
    logic        kill_regwrite_s;
    logic        timeout_s;
    logic        mem_stall_s;
    logic        misalign_s;
    logic [31:0] rdata_nxt_s;

    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [31:0] dmem_wdata_r;

    logic [31:0] instruction_r;
    logic [31:0] pc_plus_4_r;
    logic [31:0] mem_read_data_r;
    logic [31:0] alu_result_r;
    logic        jal_r;
    logic        mem_to_reg_r;
    logic        reg_dst_r;
    logic        reg_write_r;
    logic        wb_valid_r;
    logic        bus_err_r;

    // Classify the presented instruction; a read+write op is treated as a write.
    always_comb begin
        mem_op_s  = in_valid & (in_MemRead | in_MemWrite);
        aligned_s = (in_Alu_result[1:0] == 2'b00);
    end

    // Next-state, stall and completion decode for the two-state access FSM.
    always_comb begin
        state_nxt_s     = state_r;
        start_s         = 1'b0;
        complete_s      = 1'b0;
        kill_regwrite_s = 1'b0;
        timeout_s       = 1'b0;
        mem_stall_s     = 1'b0;
        misalign_s      = 1'b0;
        rdata_nxt_s     = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s && aligned_s) begin
                    mem_stall_s = 1'b1;
                    start_s     = 1'b1;
                    state_nxt_s = ST_ACCESS;
                end else if (mem_op_s) begin
                    // Misaligned: retire immediately without touching the bus.
                    misalign_s      = 1'b1;
                    complete_s      = 1'b1;
                    kill_regwrite_s = 1'b1;
                end else if (in_valid) begin
                    complete_s = 1'b1;
                end else begin
                    complete_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    // An ack in the final allowed cycle still wins over timeout.
                    complete_s  = 1'b1;
                    rdata_nxt_s = dmem_we_r ? 32'h0000_0000 : dmem_rdata;
                    state_nxt_s = ST_IDLE;
                end else if (acc_cnt_r == TIMEOUT_LAST) begin
                    complete_s      = 1'b1;
                    kill_regwrite_s = 1'b1;
                    timeout_s       = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    mem_stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, ACCESS-cycle counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            acc_cnt_r <= 8'd0;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bus_err_r <= bus_err_r | timeout_s;
            if ((state_r == ST_ACCESS) && !complete_s) begin
                acc_cnt_r <= acc_cnt_r + 8'd1;
            end else begin
                acc_cnt_r <= 8'd0;
            end
        end
    end

    // Bus request registers: captured on entry to ACCESS so they stay stable
    // for the whole access, dropped when the access ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'h0000_0000;
            dmem_wdata_r <= 32'h0000_0000;
        end else if (start_s) begin
            dmem_req_r   <= 1'b1;
            dmem_we_r    <= in_MemWrite;
            dmem_addr_r  <= in_Alu_result;
            dmem_wdata_r <= in_Store_data;
        end else if ((state_r == ST_ACCESS) && complete_s) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
        end else begin
            dmem_req_r   <= dmem_req_r;
            dmem_we_r    <= dmem_we_r;
        end
    end

    // MEM/WB bundle: loaded when an instruction retires, otherwise a bubble
    // that clears wb_valid/RegWrite and holds the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction_r   <= 32'h0000_0000;
            pc_plus_4_r     <= 32'h0000_0000;
            mem_read_data_r <= 32'h0000_0000;
            alu_result_r    <= 32'h0000_0000;
            jal_r           <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            reg_dst_r       <= 1'b0;
            reg_write_r     <= 1'b0;
            wb_valid_r      <= 1'b0;
        end else if (complete_s) begin
            instruction_r   <= in_Instruction;
            pc_plus_4_r     <= in_PC_plus_4;
            mem_read_data_r <= rdata_nxt_s;
            alu_result_r    <= in_Alu_result;
            jal_r           <= in_Jal;
            mem_to_reg_r    <= in_MemtoReg;
            reg_dst_r       <= in_RegDst;
            reg_write_r     <= in_RegWrite & ~kill_regwrite_s;
            wb_valid_r      <= 1'b1;
        end else begin
            reg_write_r     <= 1'b0;
            wb_valid_r      <= 1'b0;
        end
    end

    assign mem_stall     = mem_stall_s;
    assign misalign_err  = misalign_s;
    assign dmem_req      = dmem_req_r;
    assign dmem_we       = dmem_we_r;
    assign dmem_addr     = dmem_addr_r;
    assign dmem_wdata    = dmem_wdata_r;
    assign Instruction   = instruction_r;
    assign PC_plus_4     = pc_plus_4_r;
    assign Mem_read_data = mem_read_data_r;
    assign Alu_result    = alu_result_r;
    assign Jal           = jal_r;
    assign MemtoReg      = mem_to_reg_r;
    assign RegDst        = reg_dst_r;
    assign RegWrite      = reg_write_r;
    assign wb_valid      = wb_valid_r;
    assign bus_err       = bus_err_r;

endmodule
